multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle control sequencer for the MIPS-subset datapath: PC, IR, register bank, A/B/ALUOut registers, ula32 ALU and the shared single-port Memoria.
- Fetches, decodes and executes add, sub, and, addi, lw, sw, beq, bne and j.
- Inserts memory wait states and redirects to an exception vector on overflow or an unknown opcode.
- Sits beside the datapath in the CPU top and drives every mux select and register load.

Parameters:
- MEM_WAIT, 1: extra wait cycles before Memoria read data is valid (0..7).
- EXC_VEC, 32'h000000FC: exception handler address, driven on ExcVec for PCSource=3.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- OpCode  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Overflow  in  1  ALU overflow, combinational.
- Igual  in  1  ALU equality flag, combinational.
- PCWrite, IRWrite, MemWr, WriteRegA, WriteRegB, ALUOutControl, RegWrite, EPCWrite  out  1 each  load/write strobes.
- ALUSrcA  out  2  0=PC, 1=A.
- ALUSrcB  out  3  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- ALUOp  out  3  ula32 selector: 001 add, 010 sub, 011 and, 111 compare.
- PCSource  out  3  0=ALUResult, 1=ALUOut, 2=jump target, 3=ExcVec.
- Iord  out  3  0=PC, 1=ALUOut.
- MemToReg  out  4  0=ALUOut, 1=memory data.
- RegDst  out  2  0=rt, 1=rd.
- ExcCause  out  2  registered; 00 none, 01 bad opcode, 10 overflow.
- ExcVec  out  32  constant EXC_VEC.
- stateout  out  7  current state code.

Behaviour:
- Reset: state goes to RST (code 0) asynchronously. Every strobe is 0, every select is 0, ExcCause=00, wait counter=0. Outputs are a Moore decode of state, except the branch PCWrite.
- Defaults: any output not listed for a state is 0.
- RST(0): go to FETCH on the next edge.
- FETCH(1): Iord=0, ALUSrcA=0, ALUSrcB=1, ALUOp=001.
  - Held for MEM_WAIT+1 cycles, counted by the wait counter.
  - On the final cycle only: PCWrite=1, PCSource=0, IRWrite=1. Then go to DECODE.
- DECODE(2): WriteRegA=WriteRegB=1, ALUSrcA=0, ALUSrcB=3, ALUOp=001, ALUOutControl=1 (branch target). Next state by OpCode:
  - 0x00 -> EXEC_R.
  - 0x08 -> EXEC_I.
  - 0x23 or 0x2B -> ADDR.
  - 0x04 or 0x05 -> BRANCH.
  - 0x02 -> JUMP.
  - Any other value -> EXC with cause 01.
- EXEC_R(3): ALUSrcA=1, ALUSrcB=0, ALUOutControl=1. ALUOp: Funct 0x20 -> 001, 0x22 -> 010, 0x24 -> 011.
  - Unknown Funct -> EXC with cause 01.
  - Overflow=1 with add/sub -> EXC with cause 10.
  - Otherwise -> WB_R.
- WB_R(4): RegDst=1, MemToReg=0, RegWrite=1, then FETCH.
- EXEC_I(5): ALUSrcA=1, ALUSrcB=2, ALUOp=001, ALUOutControl=1. Overflow -> EXC with cause 10, else WB_I.
- WB_I(6): RegDst=0, MemToReg=0, RegWrite=1, then FETCH.
- ADDR(7): ALUSrcA=1, ALUSrcB=2, ALUOp=001, ALUOutControl=1. Overflow is ignored. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD(8): Iord=1 for MEM_WAIT+1 cycles, then WB_MEM.
- WB_MEM(10): Iord=1, RegDst=0, MemToReg=1, RegWrite=1, then FETCH.
- MEM_WR(9): Iord=1, MemWr=1 for exactly one cycle, then FETCH.
- BRANCH(11): ALUSrcA=1, ALUSrcB=0, ALUOp=111, PCSource=1. PCWrite=Igual for beq, !Igual for bne (Mealy). Then FETCH.
- JUMP(12): PCSource=2, PCWrite=1, then FETCH.
- EXC(13): one cycle, then FETCH.
  - ALUSrcA=0, ALUSrcB=1, ALUOp=010, EPCWrite=1 (EPC <= PC-4).
  - PCSource=3, PCWrite=1.
  - ExcCause is latched on entry and held until the next exception or reset.
- Invariants:
  - The wait counter clears on every state change.
  - RegWrite and MemWr are never both 1.
  - At most one of PCWrite/IRWrite/MemWr/RegWrite is set per cycle, except in FETCH and EXC.
- reset asserted mid-instruction aborts immediately. No strobe is issued after reset falls.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum with explicit 7-bit codes;
  - opcode and funct constants;
  - ALUOp, ALUSrcA/B, PCSource, Iord, MemToReg and RegDst encodings;
  - ExcCause codes.
- Sub-module wait_counter (3-bit, clear/enable, done flag) provides the memory wait timing for FETCH and MEM_RD.

Test Plan:
- Reset low 3 cycles, then high, MEM_WAIT=1 -> stateout 0,1,1,2. PCWrite and IRWrite pulse only on the 2nd FETCH cycle.
- OpCode 0x00, Funct 0x20, Overflow=0 -> states 1,1,2,3,4. In state 4: RegDst=1, RegWrite=1 for exactly 1 cycle.
- OpCode 0x23 -> states 2,7,8,8,10. Iord=1 in states 8 and 10, MemToReg=1 in state 10.
- OpCode 0x2B -> state 9 for exactly 1 cycle with MemWr=1, then state 1.
- OpCode 0x04 with Igual=1 -> PCWrite=1, PCSource=1 in state 11. Same with Igual=0 -> PCWrite=0. OpCode 0x05 gives the inverted result.
- OpCode 0x3F -> state 13 with ExcCause=01, PCSource=3, EPCWrite=1. Separately, addi with Overflow=1 -> ExcCause=10 and no RegWrite.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state codes, opcode/funct constants and datapath select encodings
// for the multicycle MIPS-subset controller. Rev 1.0
`default_nettype none

package ctrl_pkg;

  typedef enum logic [6:0] {
    S_RST    = 7'd0,
    S_FETCH  = 7'd1,
    S_DECODE = 7'd2,
    S_EXEC_R = 7'd3,
    S_WB_R   = 7'd4,
    S_EXEC_I = 7'd5,
    S_WB_I   = 7'd6,
    S_ADDR   = 7'd7,
    S_MEM_RD = 7'd8,
    S_MEM_WR = 7'd9,
    S_WB_MEM = 7'd10,
    S_BRANCH = 7'd11,
    S_JUMP   = 7'd12,
    S_EXC    = 7'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_CMP = 3'b111;

  localparam logic [1:0] SRCA_PC = 2'd0;
  localparam logic [1:0] SRCA_A  = 2'd1;

  localparam logic [2:0] SRCB_B       = 3'd0;
  localparam logic [2:0] SRCB_FOUR    = 3'd1;
  localparam logic [2:0] SRCB_IMM     = 3'd2;
  localparam logic [2:0] SRCB_IMM_SH2 = 3'd3;

  localparam logic [2:0] PCSRC_ALU    = 3'd0;
  localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_EXC    = 3'd3;

  localparam logic [2:0] IORD_PC     = 3'd0;
  localparam logic [2:0] IORD_ALUOUT = 3'd1;

  localparam logic [3:0] M2R_ALUOUT = 4'd0;
  localparam logic [3:0] M2R_MEM    = 4'd1;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_BADOP = 2'b01;
  localparam logic [1:0] EXC_OVF   = 2'b10;

  // ALU_NOP marks a funct field the controller does not implement.
  function automatic logic [2:0] funct_aluop(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/wait_counter.sv
// wait_counter: 3-bit memory wait-state counter with clear/enable and a
// done flag raised once LIMIT extra cycles have elapsed. Rev 1.0
`default_nettype none

module wait_counter #(
  parameter int LIMIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [2:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 3'd1;
    end
  end

  assign done = (count == 3'(LIMIT));

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute sequencer for the MIPS-subset
// multicycle datapath, with memory wait states and exception redirect. Rev 1.0
`default_nettype none

module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int          MEM_WAIT = 1,
  parameter logic [31:0] EXC_VEC  = 32'h000000FC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  Funct,
  input  logic        Overflow,
  input  logic        Igual,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemWr,
  output logic        WriteRegA,
  output logic        WriteRegB,
  output logic        ALUOutControl,
  output logic        RegWrite,
  output logic        EPCWrite,
  output logic [1:0]  ALUSrcA,
  output logic [2:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic [2:0]  PCSource,
  output logic [2:0]  Iord,
  output logic [3:0]  MemToReg,
  output logic [1:0]  RegDst,
  output logic [1:0]  ExcCause,
  output logic [31:0] ExcVec,
  output logic [6:0]  stateout
);

  state_t     state;
  logic [1:0] exc_cause;
  logic       in_wait;
  logic       wait_clear;
  logic       wait_done;

  // FETCH and MEM_RD only leave on done, so clearing on done or outside
  // those states clears the counter on every state change.
  assign in_wait    = (state == S_FETCH) || (state == S_MEM_RD);
  assign wait_clear = !in_wait || wait_done;

  wait_counter #(
    .LIMIT(MEM_WAIT)
  ) u_wait (
    .clk    (clock),
    .rst_n  (reset),
    .clear  (wait_clear),
    .enable (in_wait),
    .done   (wait_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_RST;
      exc_cause <= EXC_NONE;
    end else begin
      case (state)
        S_RST:    state <= S_FETCH;
        S_FETCH:  if (wait_done) state <= S_DECODE;
        S_DECODE: begin
          case (OpCode)
            OP_RTYPE:     state <= S_EXEC_R;
            OP_ADDI:      state <= S_EXEC_I;
            OP_LW, OP_SW: state <= S_ADDR;
            OP_BEQ, OP_BNE: state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            default: begin
              state     <= S_EXC;
              exc_cause <= EXC_BADOP;
            end
          endcase
        end
        S_EXEC_R: begin
          if (funct_aluop(Funct) == ALU_NOP) begin
            state     <= S_EXC;
            exc_cause <= EXC_BADOP;
          end else if (Overflow && (Funct == FN_ADD || Funct == FN_SUB)) begin
            state     <= S_EXC;
            exc_cause <= EXC_OVF;
          end else begin
            state <= S_WB_R;
          end
        end
        S_EXEC_I: begin
          if (Overflow) begin
            state     <= S_EXC;
            exc_cause <= EXC_OVF;
          end else begin
            state <= S_WB_I;
          end
        end
        S_ADDR:   state <= (OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: if (wait_done) state <= S_WB_MEM;
        S_WB_R, S_WB_I, S_WB_MEM, S_MEM_WR,
        S_BRANCH, S_JUMP, S_EXC: state <= S_FETCH;
        default:  state <= S_RST;
      endcase
    end
  end

  always_comb begin
    PCWrite       = 1'b0;
    IRWrite       = 1'b0;
    MemWr         = 1'b0;
    WriteRegA     = 1'b0;
    WriteRegB     = 1'b0;
    ALUOutControl = 1'b0;
    RegWrite      = 1'b0;
    EPCWrite      = 1'b0;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_B;
    ALUOp         = ALU_NOP;
    PCSource      = PCSRC_ALU;
    Iord          = IORD_PC;
    MemToReg      = M2R_ALUOUT;
    RegDst        = DST_RT;
    case (state)
      S_FETCH: begin
        Iord    = IORD_PC;
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_FOUR;
        ALUOp   = ALU_ADD;
        if (wait_done) begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_ALU;
          IRWrite  = 1'b1;
        end
      end
      S_DECODE: begin
        WriteRegA     = 1'b1;
        WriteRegB     = 1'b1;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_IMM_SH2;
        ALUOp         = ALU_ADD;
        ALUOutControl = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA       = SRCA_A;
        ALUSrcB       = SRCB_B;
        ALUOp         = funct_aluop(Funct);
        ALUOutControl = 1'b1;
      end
      S_WB_R: begin
        RegDst   = DST_RD;
        MemToReg = M2R_ALUOUT;
        RegWrite = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        ALUSrcA       = SRCA_A;
        ALUSrcB       = SRCB_IMM;
        ALUOp         = ALU_ADD;
        ALUOutControl = 1'b1;
      end
      S_WB_I: begin
        RegDst   = DST_RT;
        MemToReg = M2R_ALUOUT;
        RegWrite = 1'b1;
      end
      S_MEM_RD: Iord = IORD_ALUOUT;
      S_MEM_WR: begin
        Iord  = IORD_ALUOUT;
        MemWr = 1'b1;
      end
      S_WB_MEM: begin
        Iord     = IORD_ALUOUT;
        RegDst   = DST_RT;
        MemToReg = M2R_MEM;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = SRCA_A;
        ALUSrcB  = SRCB_B;
        ALUOp    = ALU_CMP;
        PCSource = PCSRC_ALUOUT;
        PCWrite  = (OpCode == OP_BNE) ? !Igual : Igual;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
      end
      S_EXC: begin
        ALUSrcA  = SRCA_PC;
        ALUSrcB  = SRCB_FOUR;
        ALUOp    = ALU_SUB;
        EPCWrite = 1'b1;
        PCSource = PCSRC_EXC;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ExcCause = exc_cause;
  assign ExcVec   = EXC_VEC;
  assign stateout = state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed walk through reset, R-type, lw, sw, branches,
// jump, exceptions and mid-instruction reset of multicycle_ctrl. Rev 1.0
`default_nettype none

module tb_multicycle_ctrl;

  logic        clock;
  logic        reset;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic        Overflow;
  logic        Igual;
  logic        PCWrite, IRWrite, MemWr, WriteRegA, WriteRegB;
  logic        ALUOutControl, RegWrite, EPCWrite;
  logic [1:0]  ALUSrcA;
  logic [2:0]  ALUSrcB;
  logic [2:0]  ALUOp;
  logic [2:0]  PCSource;
  logic [2:0]  Iord;
  logic [3:0]  MemToReg;
  logic [1:0]  RegDst;
  logic [1:0]  ExcCause;
  logic [31:0] ExcVec;
  logic [6:0]  stateout;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(
    .MEM_WAIT (1),
    .EXC_VEC  (32'h000000FC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .OpCode        (OpCode),
    .Funct         (Funct),
    .Overflow      (Overflow),
    .Igual         (Igual),
    .PCWrite       (PCWrite),
    .IRWrite       (IRWrite),
    .MemWr         (MemWr),
    .WriteRegA     (WriteRegA),
    .WriteRegB     (WriteRegB),
    .ALUOutControl (ALUOutControl),
    .RegWrite      (RegWrite),
    .EPCWrite      (EPCWrite),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUOp         (ALUOp),
    .PCSource      (PCSource),
    .Iord          (Iord),
    .MemToReg      (MemToReg),
    .RegDst        (RegDst),
    .ExcCause      (ExcCause),
    .ExcVec        (ExcVec),
    .stateout      (stateout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check the state code there.
  task automatic st(input int n);
    @(negedge clock);
    chk($sformatf("state_%0d", n), 32'(stateout), 32'(n));
  endtask

  initial begin
    reset = 1'b0; OpCode = 6'h00; Funct = 6'h20; Overflow = 1'b0; Igual = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_state", 32'(stateout), 32'd0);
    chk("rst_strobes", 32'({PCWrite, IRWrite, MemWr, WriteRegA, WriteRegB,
                            ALUOutControl, RegWrite, EPCWrite}), 32'd0);
    chk("rst_selects", 32'({ALUSrcA, ALUSrcB, ALUOp, PCSource, Iord, MemToReg, RegDst}), 32'd0);
    chk("rst_cause", 32'(ExcCause), 32'd0);
    chk("excvec", ExcVec, 32'h000000FC);
    reset = 1'b1;

    // Fetch, then add
    st(1);
    chk("f1_pcwrite", 32'(PCWrite), 32'd0);
    chk("f1_irwrite", 32'(IRWrite), 32'd0);
    chk("f1_srcb", 32'(ALUSrcB), 32'd1);
    chk("f1_aluop", 32'(ALUOp), 32'd1);
    st(1);
    chk("f2_pcwrite", 32'(PCWrite), 32'd1);
    chk("f2_irwrite", 32'(IRWrite), 32'd1);
    chk("f2_pcsource", 32'(PCSource), 32'd0);
    st(2);
    chk("dec_wra_wrb", 32'({WriteRegA, WriteRegB}), 32'd3);
    chk("dec_srcb", 32'(ALUSrcB), 32'd3);
    chk("dec_aluout", 32'(ALUOutControl), 32'd1);
    chk("dec_pcwrite", 32'(PCWrite), 32'd0);
    st(3);
    chk("exr_srca", 32'(ALUSrcA), 32'd1);
    chk("exr_srcb", 32'(ALUSrcB), 32'd0);
    chk("exr_aluop_add", 32'(ALUOp), 32'd1);
    st(4);
    chk("wbr_regdst", 32'(RegDst), 32'd1);
    chk("wbr_regwrite", 32'(RegWrite), 32'd1);
    st(1);
    chk("after_wbr_regwrite", 32'(RegWrite), 32'd0);

    // lw
    st(1); OpCode = 6'h23;
    st(2); st(7);
    chk("addr_srcb", 32'(ALUSrcB), 32'd2);
    st(8);
    chk("memrd1_iord", 32'(Iord), 32'd1);
    st(8);
    chk("memrd2_iord", 32'(Iord), 32'd1);
    st(10);
    chk("wbm_iord", 32'(Iord), 32'd1);
    chk("wbm_memtoreg", 32'(MemToReg), 32'd1);
    chk("wbm_regwrite", 32'(RegWrite), 32'd1);
    chk("wbm_memwr", 32'(MemWr), 32'd0);

    // sw
    st(1); st(1); OpCode = 6'h2B;
    st(2); st(7); st(9);
    chk("memwr_memwr", 32'(MemWr), 32'd1);
    chk("memwr_regwrite", 32'(RegWrite), 32'd0);
    chk("memwr_iord", 32'(Iord), 32'd1);
    st(1);
    chk("after_sw_memwr", 32'(MemWr), 32'd0);

    // beq taken / not taken, bne
    st(1); OpCode = 6'h04; Igual = 1'b1;
    st(2); st(11);
    chk("beq_t_pcwrite", 32'(PCWrite), 32'd1);
    chk("beq_t_pcsource", 32'(PCSource), 32'd1);
    chk("beq_t_aluop", 32'(ALUOp), 32'd7);
    st(1); st(1); Igual = 1'b0;
    st(2); st(11);
    chk("beq_nt_pcwrite", 32'(PCWrite), 32'd0);
    st(1); st(1); OpCode = 6'h05;
    st(2); st(11);
    chk("bne_t_pcwrite", 32'(PCWrite), 32'd1);
    Igual = 1'b1;
    #1;
    chk("bne_nt_pcwrite", 32'(PCWrite), 32'd0);

    // sub selects ALUOp 010
    st(1); st(1); OpCode = 6'h00; Funct = 6'h22; Igual = 1'b0;
    st(2); st(3);
    chk("exr_aluop_sub", 32'(ALUOp), 32'd2);
    st(4);

    // Unknown opcode
    st(1); st(1); OpCode = 6'h3F;
    st(2); st(13);
    chk("badop_cause", 32'(ExcCause), 32'd1);
    chk("badop_pcsource", 32'(PCSource), 32'd3);
    chk("badop_epcwrite", 32'(EPCWrite), 32'd1);
    chk("badop_pcwrite", 32'(PCWrite), 32'd1);
    chk("badop_aluop", 32'(ALUOp), 32'd2);
    st(1);
    chk("badop_cause_held", 32'(ExcCause), 32'd1);
    chk("after_exc_epcwrite", 32'(EPCWrite), 32'd0);

    // addi overflow
    st(1); OpCode = 6'h08; Overflow = 1'b1;
    st(2); st(5);
    chk("exi_srcb", 32'(ALUSrcB), 32'd2);
    chk("exi_regwrite", 32'(RegWrite), 32'd0);
    st(13);
    chk("ovf_cause", 32'(ExcCause), 32'd2);
    chk("ovf_regwrite", 32'(RegWrite), 32'd0);
    Overflow = 1'b0;
    st(1);

    // Reset mid-instruction aborts immediately
    st(1); OpCode = 6'h00; Funct = 6'h20;
    st(2); st(3);
    reset = 1'b0;
    #1;
    chk("midrst_state", 32'(stateout), 32'd0);
    chk("midrst_cause", 32'(ExcCause), 32'd0);
    chk("midrst_strobes", 32'({PCWrite, IRWrite, MemWr, RegWrite, ALUOutControl}), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Jump
    st(1); st(1); OpCode = 6'h02;
    st(2); st(12);
    chk("jump_pcwrite", 32'(PCWrite), 32'd1);
    chk("jump_pcsource", 32'(PCSource), 32'd2);
    st(1);
    chk("after_jump_pcwrite", 32'(PCWrite), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
